// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int ALIGN_BITS  = $clog2(INSTR_BYTES);

    // Fetch sequencer control states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_HALTED = 3'd5
    } fetch_state_t;

    // A fetch target is usable only if it lands on an instruction boundary.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[ALIGN_BITS-1:0] == '0;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory request at a time from the
// external program counter, hands the returned word to decode, and steers the
// program counter on accepts (+4) and redirects (load). Responses belonging to
// an abandoned fetch are drained and dropped before fetching resumes.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            halt,
    input  logic [XLEN-1:0] pc_cur,
    output logic            pc_load,
    output logic            pc_inc,
    output logic [XLEN-1:0] pc_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misaligned,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic active;
    logic redir_ok;
    logic redir_bad;
    logic stop_now;
    logic capture;

    // Redirects only mean something while a fetch stream is running.
    assign active    = (state == ST_REQ) || (state == ST_WAIT) ||
                       (state == ST_DRAIN) || (state == ST_HOLD);
    assign redir_ok  = active && redirect && is_aligned(redirect_pc);
    assign redir_bad = active && redirect && !is_aligned(redirect_pc);
    // Once nothing is outstanding, any of these means fetching must stop.
    assign stop_now  = halt || misaligned || redir_bad;
    // A word is kept for decode only if this fetch is neither redirected nor halted.
    assign capture   = (state == ST_WAIT) && imem_rvalid && !redirect && !halt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; redirects take precedence over normal progress.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    // A granted request still owes a response that must be dropped.
                    if (imem_gnt)      state_next = ST_DRAIN;
                    else if (stop_now) state_next = ST_HALTED;
                end else if (imem_gnt) begin
                    state_next = ST_WAIT;
                end else if (halt) begin
                    state_next = ST_HALTED;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    if (!imem_rvalid)  state_next = ST_DRAIN;
                    else if (stop_now) state_next = ST_HALTED;
                    else               state_next = ST_REQ;
                end else if (imem_rvalid) begin
                    state_next = halt ? ST_HALTED : ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) state_next = stop_now ? ST_HALTED : ST_REQ;
            end
            ST_HOLD: begin
                if (redirect)         state_next = stop_now ? ST_HALTED : ST_REQ;
                else if (instr_ready) state_next = halt ? ST_HALTED : ST_REQ;
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes decoded from the current state and this cycle's inputs.
    always_comb begin
        imem_req    = (state == ST_REQ);
        imem_addr   = pc_cur;
        pc_load     = redir_ok;
        pc_target   = redirect_pc;
        // A redirect kills the held instruction in the same cycle, so it can
        // never be accepted alongside a PC load.
        instr_valid = (state == ST_HOLD) && !redirect;
        pc_inc      = (state == ST_HOLD) && !redirect && instr_ready;
    end

    // Instruction word and its address, held stable while decode stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (capture) begin
            instr    <= imem_rdata;
            instr_pc <= pc_cur;
        end
    end

    // Accepted-instruction counter; wraps naturally at the top of its range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (pc_inc) begin
            fetch_count <= fetch_count + 1'b1;
        end
    end

    // Misaligned-target flag stays set until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned <= 1'b0;
        end else if (redir_bad) begin
            misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A flag-based fetch model predicts every
// output each cycle; per-cycle literal expectations pin the model to
// hand-computed values.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] pc_cur;
    logic        pc_load;
    logic        pc_inc;
    logic [31:0] pc_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        misaligned;
    logic [31:0] fetch_count;

    int checks = 0;
    int failures = 0;

    localparam int L_REQ = 1, L_ADDR = 2, L_LOAD = 3, L_TARGET = 4, L_INC = 5;
    localparam int L_VALID = 6, L_INSTR = 7, L_IPC = 8, L_FCNT = 9, L_MIS = 10;

    int          lit_n = 0;
    int          lit_code [8];
    logic [31:0] lit_val  [8];
    logic        preset_req = 1'b0;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .pc_cur(pc_cur),
        .pc_load(pc_load), .pc_inc(pc_inc), .pc_target(pc_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .misaligned(misaligned), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Neighbouring program counter block.
    always @(posedge clk or posedge rst) begin
        if (rst)          pc_cur <= '0;
        else if (pc_load) pc_cur <= pc_target;
        else if (pc_inc)  pc_cur <= pc_cur + 32'd4;
    end

    // Model state: a fetch stream is either not started, stopped for good, or
    // running with at most one outstanding request or one held instruction.
    logic        m_active, m_stopped, m_out, m_drop, m_have, m_mis;
    logic [31:0] m_instr, m_ipc, m_cnt, m_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic string lit_name(input int c);
        case (c)
            L_REQ: return "lit_imem_req";      L_ADDR: return "lit_imem_addr";
            L_LOAD: return "lit_pc_load";      L_TARGET: return "lit_pc_target";
            L_INC: return "lit_pc_inc";        L_VALID: return "lit_instr_valid";
            L_INSTR: return "lit_instr";       L_IPC: return "lit_instr_pc";
            L_FCNT: return "lit_fetch_count";  default: return "lit_misaligned";
        endcase
    endfunction

    // Compare process: predict, compare, then advance the model past the coming edge.
    always @(negedge clk) begin
        logic act, exp_req, exp_load, exp_valid, exp_inc;
        logic [31:0] lv;
        if (rst) begin
            m_active = 0; m_stopped = 0; m_out = 0; m_drop = 0; m_have = 0; m_mis = 0;
            m_instr = 0; m_ipc = 0; m_cnt = 0; m_pc = 0;
        end
        act       = m_active && !m_stopped;
        exp_req   = act && !m_out && !m_have;
        exp_load  = act && redirect && (redirect_pc[1:0] == 2'b00);
        exp_valid = act && m_have && !redirect;
        exp_inc   = exp_valid && instr_ready;

        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("pc_load", {31'd0, pc_load}, {31'd0, exp_load});
        if (exp_load) chk("pc_target", pc_target, redirect_pc);
        chk("pc_inc", {31'd0, pc_inc}, {31'd0, exp_inc});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("fetch_count", fetch_count, m_cnt);
        chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});

        for (int i = 0; i < lit_n; i++) begin
            case (lit_code[i])
                L_REQ:    lv = {31'd0, imem_req};
                L_ADDR:   lv = imem_addr;
                L_LOAD:   lv = {31'd0, pc_load};
                L_TARGET: lv = pc_target;
                L_INC:    lv = {31'd0, pc_inc};
                L_VALID:  lv = {31'd0, instr_valid};
                L_INSTR:  lv = instr;
                L_IPC:    lv = instr_pc;
                L_FCNT:   lv = fetch_count;
                default:  lv = {31'd0, misaligned};
            endcase
            chk(lit_name(lit_code[i]), lv, lit_val[i]);
        end

        if (!rst) begin
            if (!m_active) begin
                if (start) m_active = 1;
            end else if (!m_stopped) begin
                if (redirect) begin
                    if (redirect_pc[1:0] != 2'b00) m_mis = 1;
                    else m_pc = redirect_pc;
                    m_have = 0;
                    if (exp_req) begin
                        if (imem_gnt) begin m_out = 1; m_drop = 1; end
                    end else if (m_out) begin
                        if (imem_rvalid) m_out = 0;
                        else m_drop = 1;
                    end
                    if (!m_out) m_stopped = halt || m_mis;
                end else if (exp_req) begin
                    if (imem_gnt) begin m_out = 1; m_drop = 0; end
                    else if (halt) m_stopped = 1;
                end else if (m_out) begin
                    if (imem_rvalid) begin
                        m_out = 0;
                        if (m_drop || halt) m_stopped = halt || m_mis;
                        else begin m_have = 1; m_instr = imem_rdata; m_ipc = m_pc; end
                    end
                end else if (m_have && instr_ready) begin
                    m_have = 0; m_cnt = m_cnt + 32'd1; m_pc = m_pc + 32'd4; m_stopped = halt;
                end
            end
            if (preset_req) begin
                dut.fetch_count = 32'hFFFF_FFFF;
                m_cnt = 32'hFFFF_FFFF;
            end
        end
    end

    task automatic lit(input int code, input logic [31:0] val);
        lit_code[lit_n] = code;
        lit_val[lit_n]  = val;
        lit_n++;
    endtask

    // One clock cycle of stimulus: start, halt, gnt, rvalid, rdata, ready, redirect, redirect_pc.
    task automatic cyc(input logic st, input logic hl, input logic g, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic rdr,
                       input logic [31:0] rpc);
        @(posedge clk); #1;
        lit_n = 0; preset_req = 0;
        start = st; halt = hl; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        instr_ready = rdy; redirect = rdr; redirect_pc = rpc;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        lit_n = 0; preset_req = 0; rst = 1;
        start = 0; halt = 0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        instr_ready = 0; redirect = 0; redirect_pc = 0;
        lit(L_FCNT, 0); lit(L_MIS, 0); lit(L_REQ, 0);
        @(posedge clk); #1;
        lit_n = 0; rst = 0;
    endtask

    initial begin
        // Basic fetch of 0x13 at PC 0 and accept.
        do_reset();
        cyc(1,0,0,0,0,0,0,0);
        cyc(1,0,1,0,0,0,0,0);              lit(L_REQ, 1); lit(L_ADDR, 0);
        cyc(1,0,0,1,32'h13,0,0,0);
        cyc(1,0,0,0,0,1,0,0);              lit(L_INSTR, 32'h13); lit(L_IPC, 0); lit(L_VALID, 1); lit(L_INC, 1);
        cyc(1,0,1,0,0,0,0,0);              lit(L_FCNT, 1); lit(L_ADDR, 4); lit(L_REQ, 1);
        // Decode stalls for five cycles.
        cyc(1,0,0,1,32'hDEADBEEF,0,0,0);
        repeat (5) begin
            cyc(1,0,0,0,0,0,0,0);          lit(L_VALID, 1); lit(L_INSTR, 32'hDEADBEEF); lit(L_INC, 0);
        end
        cyc(1,0,0,0,0,1,0,0);              lit(L_INC, 1); lit(L_IPC, 4);
        cyc(1,0,1,0,0,0,0,0);              lit(L_FCNT, 2); lit(L_ADDR, 8);
        // Redirect while waiting; stale response drained.
        cyc(1,0,0,0,0,0,1,32'h100);        lit(L_LOAD, 1); lit(L_TARGET, 32'h100); lit(L_VALID, 0);
        cyc(1,0,0,0,0,0,0,0);              lit(L_REQ, 0);
        cyc(1,0,0,1,32'hBAD0BAD0,0,0,0);   lit(L_VALID, 0); lit(L_REQ, 0);
        cyc(1,0,1,0,0,0,0,0);              lit(L_ADDR, 32'h100); lit(L_REQ, 1); lit(L_INSTR, 32'hDEADBEEF);
        cyc(1,0,0,1,32'h00500093,0,0,0);
        cyc(1,0,0,0,0,1,0,0);              lit(L_INSTR, 32'h00500093); lit(L_IPC, 32'h100);
        // Redirect and ready together in HOLD.
        cyc(1,0,1,0,0,0,0,0);              lit(L_ADDR, 32'h104);
        cyc(1,0,0,1,32'h11,0,0,0);
        cyc(1,0,0,0,0,1,1,32'h200);        lit(L_LOAD, 1); lit(L_INC, 0); lit(L_VALID, 0);
        cyc(1,0,0,0,0,0,0,0);              lit(L_FCNT, 3); lit(L_ADDR, 32'h200); lit(L_REQ, 1);
        // Halt while waiting: response completes, then halted for good.
        cyc(1,0,1,0,0,0,0,0);
        cyc(1,1,0,0,0,0,0,0);              lit(L_REQ, 0);
        cyc(1,1,0,1,32'h77,0,0,0);
        cyc(1,1,0,0,0,0,0,0);              lit(L_REQ, 0); lit(L_VALID, 0);
        cyc(1,0,1,0,0,0,1,32'h300);        lit(L_LOAD, 0); lit(L_REQ, 0); lit(L_FCNT, 3);

        // Counter wrap on accept, with halt during the handshake.
        do_reset();
        preset_req = 1;
        cyc(1,0,0,0,0,0,0,0);              lit(L_FCNT, 32'hFFFF_FFFF);
        cyc(1,0,1,0,0,0,0,0);
        cyc(1,0,0,1,32'h2A,0,0,0);
        cyc(1,1,0,0,0,1,0,0);              lit(L_INC, 1); lit(L_VALID, 1);
        cyc(1,1,0,0,0,0,0,0);              lit(L_FCNT, 0); lit(L_REQ, 0);
        cyc(1,0,0,1,32'h55,0,0,0);         lit(L_VALID, 0); lit(L_INSTR, 32'h2A);

        // Misaligned redirect while waiting.
        do_reset();
        cyc(1,0,0,0,0,0,0,0);
        cyc(1,0,1,0,0,0,0,0);
        cyc(1,0,0,0,0,0,1,32'h102);        lit(L_LOAD, 0); lit(L_MIS, 0);
        cyc(1,0,0,0,0,0,0,0);              lit(L_MIS, 1); lit(L_REQ, 0);
        cyc(1,0,0,1,32'h66,0,0,0);
        cyc(1,0,1,0,0,0,0,0);              lit(L_REQ, 0); lit(L_MIS, 1);
        cyc(1,0,1,0,0,0,0,0);              lit(L_REQ, 0); lit(L_INSTR, 0);

        // Reset mid-transaction; the late response in IDLE is ignored.
        do_reset();
        cyc(1,0,0,0,0,0,0,0);
        cyc(1,0,1,0,0,0,0,0);
        cyc(1,0,0,0,0,0,0,0);
        do_reset();
        cyc(0,0,0,1,32'hEE,0,0,0);         lit(L_VALID, 0); lit(L_INSTR, 0); lit(L_REQ, 0);
        cyc(1,0,0,0,0,0,0,0);
        cyc(1,0,1,0,0,0,0,0);              lit(L_ADDR, 0);
        cyc(1,0,0,1,32'h99,0,0,0);
        cyc(1,0,0,0,0,1,0,0);              lit(L_INSTR, 32'h99); lit(L_IPC, 0);
        cyc(0,0,0,0,0,0,0,0);              lit(L_FCNT, 1); lit(L_ADDR, 4);

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 start  in  1  level; enables fetching out of IDLE.
REQ-004 halt  in  1  level; request to stop fetching.
REQ-005 pc_cur  in  32  current PC from program counter block.
REQ-006 pc_load  out  1  load strobe to program counter.
REQ-007 pc_inc  out  1  +4 strobe to program counter.
REQ-008 pc_target  out  32  load value to program counter.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  request address.
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  read data valid (exactly one per granted request, ≥1 cycle after gnt).
REQ-013 imem_rdata  in  32  read data.
REQ-014 instr_valid / instr / instr_pc  out  1/32/32  fetched instruction to decode.
REQ-015 instr_ready  in  1  decode accepts instruction.
REQ-016 redirect / redirect_pc  in  1/32  branch/jump/trap target.
REQ-017 misaligned  out  1  sticky misaligned-target flag.
REQ-018 fetch_count  out  32  accepted-instruction counter.

Function
REQ-019 States SHALL be IDLE, REQ, WAIT, DRAIN, HOLD, HALTED.
REQ-020 IDLE: all strobes 0; start=1 -> REQ.
REQ-021 REQ: imem_req=1, imem_addr=pc_cur (combinational); gnt=1 -> WAIT, else stay.
REQ-022 WAIT: on rvalid capture imem_rdata into instr, pc_cur into instr_pc -> HOLD.
REQ-023 HOLD: instr_valid=1; instr/instr_pc stable until handshake; instr_ready=1 -> pc_inc=1 for one cycle, fetch_count+1 (wraps 0xFFFFFFFF->0), next REQ (or HALTED if halt=1).
REQ-024 Redirect (states REQ/WAIT/HOLD, redirect_pc[1:0]==0): pc_load=1, pc_target=redirect_pc same cycle; instr_valid forced 0 that cycle; no fetch_count increment.
REQ-025 Redirect next state: REQ without gnt -> REQ; REQ with gnt, or WAIT without rvalid -> DRAIN; WAIT with rvalid (data discarded) -> REQ; HOLD -> REQ.
REQ-026 DRAIN: imem_req=0; rvalid discarded -> REQ (HALTED if halt=1); a further redirect in DRAIN reloads PC, stays DRAIN.
REQ-027 Redirect SHALL take priority over instr_ready in HOLD; pc_load and pc_inc SHALL never assert together.
REQ-028 redirect_pc[1:0]!=0: no pc_load; misaligned set (sticky until reset); outstanding response drained, then HALTED.
REQ-029 halt: honoured only with no outstanding transaction — REQ without gnt -> HALTED; HOLD -> HALTED after handshake completes; WAIT/DRAIN after rvalid.
REQ-030 HALTED: all strobes 0; exits only by reset; redirect ignored in IDLE and HALTED.
REQ-031 imem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-032 rst asynchronously forces IDLE; pc_load, pc_inc, imem_req, instr_valid, misaligned = 0; instr, instr_pc, fetch_count = 0.
REQ-033 Reset mid-transaction abandons it; first post-reset rvalid in IDLE ignored.

Structure
REQ-034 Package fetch_pkg SHALL hold state enum fetch_state_t, INSTR_BYTES=4, XLEN=32.
REQ-035 Single module, no sub-module; drives the team program counter block externally; outputs pc_load/pc_inc/imem_req/instr_valid decoded from registered state plus current inputs.

Verification
REQ-036 Reset, start=1, pc_cur=0, gnt immediate, rvalid 1 cycle later rdata=0x00000013, ready=1 -> instr=0x13, instr_pc=0, pc_inc pulse, fetch_count=1, next imem_addr=4.
REQ-037 HOLD with instr_ready=0 for 5 cycles -> instr_valid held, instr stable, pc_inc=0 throughout.
REQ-038 redirect to 0x100 in WAIT, rvalid 2 cycles later -> pc_load, pc_target=0x100, DRAIN, old data discarded, next imem_addr=0x100, no instr_valid for old data.
REQ-039 HOLD with redirect=1 and instr_ready=1 same cycle -> pc_load=1, pc_inc=0, fetch_count unchanged.
REQ-040 redirect_pc=0x102 -> misaligned=1, no pc_load, HALTED, imem_req stays 0.
REQ-041 halt=1 in WAIT -> rvalid completes, then HALTED; fetch_count preset 0xFFFFFFFF plus one accept -> 0.
